// File: rtl/snow64_lar_element_sequencer_pkg.sv
// Shared CPU package: data-type encodings plus the LAR element sequencer's
// state type and width constants.
//
// Contents:
//   DataType      operand data type (unsigned int, signed int, BFloat16, reserved)
//   IntTypeSize   SIMD lane size used by the sub-ALU for the int types
//   LarSeqState   sequencer FSM states
//   LarDataWidth / SubDataWidth / BFloat16Width / OperWidth   default widths
//   LarIntElemCount / LarBf16ElemCount                        elements per LAR
package PkgSnow64Cpu;

  typedef enum logic [1:0] {
    DataTypUnsgnInt = 2'd0,
    DataTypSgnInt   = 2'd1,
    DataTypBFloat16 = 2'd2,
    DataTypReserved = 2'd3
  } DataType;

  typedef enum logic [1:0] {
    IntTypSz8  = 2'd0,
    IntTypSz16 = 2'd1,
    IntTypSz32 = 2'd2,
    IntTypSz64 = 2'd3
  } IntTypeSize;

  typedef enum logic [1:0] {
    LarSeqIdle  = 2'd0,
    LarSeqIssue = 2'd1,
    LarSeqWait  = 2'd2,
    LarSeqDone  = 2'd3
  } LarSeqState;

  localparam int LarDataWidth     = 256;
  localparam int SubDataWidth     = 64;
  localparam int BFloat16Width    = 16;
  localparam int OperWidth        = 4;
  localparam int LarIntElemCount  = LarDataWidth / SubDataWidth;
  localparam int LarBf16ElemCount = LarDataWidth / BFloat16Width;

endpackage

// File: rtl/snow64_lar_element_sequencer_slice.sv
// snow64_lar_slice_select: combinational index -> slice mux over a LAR value.
//
// Ports:
//   larData  in   WIDTH__LAR_DATA  full LAR operand
//   index    in   WIDTH__INDEX     element index (BF16 granularity width)
//   isBf16   in   1                1: 16-bit element, zero-extended; 0: 64-bit chunk
//   slice    out  WIDTH__SUB_DATA  selected slice, little-endian element order
module snow64_lar_slice_select
  import PkgSnow64Cpu::*;
#(
  parameter int WIDTH__LAR_DATA = LarDataWidth,
  parameter int WIDTH__SUB_DATA = SubDataWidth,
  parameter int WIDTH__BFLOAT16 = BFloat16Width,
  parameter int WIDTH__INDEX    = $clog2(WIDTH__LAR_DATA / WIDTH__BFLOAT16)
) (
  input  logic [WIDTH__LAR_DATA-1:0] larData,
  input  logic [WIDTH__INDEX-1:0]    index,
  input  logic                       isBf16,
  output logic [WIDTH__SUB_DATA-1:0] slice
);

  localparam int IntIdxW = $clog2(WIDTH__LAR_DATA / WIDTH__SUB_DATA);

  // Int chunks only need the low index bits; the upper bits are always
  // zero for int ops because the index stops at the last chunk.
  logic [IntIdxW-1:0] intIdx;
  assign intIdx = index[IntIdxW-1:0];

  always_comb begin
    slice = '0;
    if (isBf16) begin
      slice[WIDTH__BFLOAT16-1:0] = larData[index*WIDTH__BFLOAT16 +: WIDTH__BFLOAT16];
    end else begin
      slice = larData[intIdx*WIDTH__SUB_DATA +: WIDTH__SUB_DATA];
    end
  end

endmodule

// File: rtl/snow64_lar_element_sequencer.sv
// snow64_lar_element_sequencer: runs one LAR-wide binary op through a shared
// 64-bit sub-ALU, one chunk (int types) or one BF16 element at a time, and
// assembles the result.
//
// Optional feature: define SNOW64_LAR_SEQ_ABORT_EN to add the in_abort input,
// which ends an in-flight op early with out_bad_type=1 and partial out_data.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_start            request strobe, taken only while out_ready=1
//   in_data_type        DataType of the operands
//   in_int_type_size    IntTypeSize (meaningful for int types only)
//   in_oper             opcode, forwarded to the sub-ALU
//   in_a, in_b          LAR operands
//   in_abort            (SNOW64_LAR_SEQ_ABORT_EN only) abandon current op
//   in_sub_valid        sub-ALU result strobe
//   in_sub_data         sub-ALU result (BF16 uses [15:0])
//   out_ready           idle, can accept in_start
//   out_valid           one-cycle completion pulse
//   out_data            assembled result, held until the next accepted start
//   out_bad_type        with out_valid: reserved type (or aborted op)
//   out_sub_start       one-cycle issue pulse to the sub-ALU
//   out_sub_a/_b        sub-ALU operands for the current index
//   out_sub_data_type   latched data type
//   out_sub_int_size    latched int size
//   out_sub_oper        latched opcode
module snow64_lar_element_sequencer
  import PkgSnow64Cpu::*;
#(
  parameter int WIDTH__LAR_DATA = LarDataWidth,
  parameter int WIDTH__SUB_DATA = SubDataWidth,
  parameter int WIDTH__BFLOAT16 = BFloat16Width,
  parameter int WIDTH__OPER     = OperWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_start,
  input  logic [1:0]                 in_data_type,
  input  logic [1:0]                 in_int_type_size,
  input  logic [WIDTH__OPER-1:0]     in_oper,
  input  logic [WIDTH__LAR_DATA-1:0] in_a,
  input  logic [WIDTH__LAR_DATA-1:0] in_b,
`ifdef SNOW64_LAR_SEQ_ABORT_EN
  input  logic                       in_abort,
`endif
  input  logic                       in_sub_valid,
  input  logic [WIDTH__SUB_DATA-1:0] in_sub_data,
  output logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH__LAR_DATA-1:0] out_data,
  output logic                       out_bad_type,
  output logic                       out_sub_start,
  output logic [WIDTH__SUB_DATA-1:0] out_sub_a,
  output logic [WIDTH__SUB_DATA-1:0] out_sub_b,
  output logic [1:0]                 out_sub_data_type,
  output logic [1:0]                 out_sub_int_size,
  output logic [WIDTH__OPER-1:0]     out_sub_oper
);

  localparam int IntElems = WIDTH__LAR_DATA / WIDTH__SUB_DATA;
  localparam int BfElems  = WIDTH__LAR_DATA / WIDTH__BFLOAT16;
  localparam int IdxW     = $clog2(BfElems);
  localparam int IntIdxW  = $clog2(IntElems);

  localparam logic [IdxW-1:0] IntLast = IdxW'(IntElems - 1);
  localparam logic [IdxW-1:0] BfLast  = IdxW'(BfElems - 1);

  LarSeqState state, nextState;

  logic [IdxW-1:0]            index;
  logic                       isBf16;
  logic                       badFlag;
  logic [WIDTH__LAR_DATA-1:0] latA;
  logic [WIDTH__LAR_DATA-1:0] latB;
  logic [WIDTH__LAR_DATA-1:0] outData;
  logic [1:0]                 subDataType;
  logic [1:0]                 subIntSize;
  logic [WIDTH__OPER-1:0]     subOper;

  logic [IdxW-1:0]    lastIdx;
  logic [IntIdxW-1:0] intIdx;
  logic               acceptStart;
  logic               abortHit;
  logic               subAccept;

  assign lastIdx     = isBf16 ? BfLast : IntLast;
  assign intIdx      = index[IntIdxW-1:0];
  assign acceptStart = (state == LarSeqIdle) && in_start;

`ifdef SNOW64_LAR_SEQ_ABORT_EN
  assign abortHit = in_abort && ((state == LarSeqIssue) || (state == LarSeqWait));
`else
  assign abortHit = 1'b0;
`endif

  // An abort in the same cycle as a sub-ALU result drops that result.
  assign subAccept = (state == LarSeqWait) && in_sub_valid && !abortHit;

  // Operands come straight from the latched LAR values, so they stay stable
  // for as long as the index does (all of ISSUE and WAIT).
  snow64_lar_slice_select #(
    .WIDTH__LAR_DATA(WIDTH__LAR_DATA),
    .WIDTH__SUB_DATA(WIDTH__SUB_DATA),
    .WIDTH__BFLOAT16(WIDTH__BFLOAT16),
    .WIDTH__INDEX   (IdxW)
  ) sliceA (
    .larData(latA),
    .index  (index),
    .isBf16 (isBf16),
    .slice  (out_sub_a)
  );

  snow64_lar_slice_select #(
    .WIDTH__LAR_DATA(WIDTH__LAR_DATA),
    .WIDTH__SUB_DATA(WIDTH__SUB_DATA),
    .WIDTH__BFLOAT16(WIDTH__BFLOAT16),
    .WIDTH__INDEX   (IdxW)
  ) sliceB (
    .larData(latB),
    .index  (index),
    .isBf16 (isBf16),
    .slice  (out_sub_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LarSeqIdle;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState     = state;
    out_ready     = 1'b0;
    out_valid     = 1'b0;
    out_bad_type  = 1'b0;
    out_sub_start = 1'b0;
    case (state)
      LarSeqIdle: begin
        out_ready = 1'b1;
        if (in_start) begin
          nextState = (in_data_type == DataTypReserved) ? LarSeqDone : LarSeqIssue;
        end
      end
      LarSeqIssue: begin
        out_sub_start = 1'b1;
        nextState     = abortHit ? LarSeqDone : LarSeqWait;
      end
      LarSeqWait: begin
        if (abortHit) begin
          nextState = LarSeqDone;
        end else if (in_sub_valid) begin
          nextState = (index == lastIdx) ? LarSeqDone : LarSeqIssue;
        end
      end
      LarSeqDone: begin
        out_valid    = 1'b1;
        out_bad_type = badFlag;
        nextState    = LarSeqIdle;
      end
      default: nextState = LarSeqIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index       <= '0;
      isBf16      <= 1'b0;
      badFlag     <= 1'b0;
      latA        <= '0;
      latB        <= '0;
      outData     <= '0;
      subDataType <= '0;
      subIntSize  <= '0;
      subOper     <= '0;
    end else begin
      if (acceptStart) begin
        index       <= '0;
        outData     <= '0;
        latA        <= in_a;
        latB        <= in_b;
        subDataType <= in_data_type;
        subIntSize  <= in_int_type_size;
        subOper     <= in_oper;
        isBf16      <= (in_data_type == DataTypBFloat16);
        badFlag     <= (in_data_type == DataTypReserved);
      end
      if (subAccept) begin
        if (isBf16) begin
          outData[index*WIDTH__BFLOAT16 +: WIDTH__BFLOAT16] <= in_sub_data[WIDTH__BFLOAT16-1:0];
        end else begin
          outData[intIdx*WIDTH__SUB_DATA +: WIDTH__SUB_DATA] <= in_sub_data;
        end
        if (index != lastIdx) begin
          index <= index + 1'b1;
        end
      end
      if (abortHit) begin
        badFlag <= 1'b1;
      end
    end
  end

  assign out_data          = outData;
  assign out_sub_data_type = subDataType;
  assign out_sub_int_size  = subIntSize;
  assign out_sub_oper      = subOper;

endmodule

// File: tb/tb_snow64_lar_element_sequencer.sv
// Testbench for snow64_lar_element_sequencer. Contains a responding sub-ALU
// model (lane-wise add, answers K cycles after each issue) and a reference
// model that computes the whole LAR result directly from the operands.
// Define SNOW64_LAR_SEQ_ABORT_EN to also exercise in_abort.
module tb_snow64_lar_element_sequencer;
  import PkgSnow64Cpu::*;

  logic         clk;
  logic         rst;
  logic         in_start;
  logic [1:0]   in_data_type;
  logic [1:0]   in_int_type_size;
  logic [3:0]   in_oper;
  logic [255:0] in_a;
  logic [255:0] in_b;
  logic         in_abort;
  logic         in_sub_valid;
  logic [63:0]  in_sub_data;
  logic         out_ready;
  logic         out_valid;
  logic [255:0] out_data;
  logic         out_bad_type;
  logic         out_sub_start;
  logic [63:0]  out_sub_a;
  logic [63:0]  out_sub_b;
  logic [1:0]   out_sub_data_type;
  logic [1:0]   out_sub_int_size;
  logic [3:0]   out_sub_oper;

  snow64_lar_element_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .in_start         (in_start),
    .in_data_type     (in_data_type),
    .in_int_type_size (in_int_type_size),
    .in_oper          (in_oper),
    .in_a             (in_a),
    .in_b             (in_b),
`ifdef SNOW64_LAR_SEQ_ABORT_EN
    .in_abort         (in_abort),
`endif
    .in_sub_valid     (in_sub_valid),
    .in_sub_data      (in_sub_data),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_bad_type     (out_bad_type),
    .out_sub_start    (out_sub_start),
    .out_sub_a        (out_sub_a),
    .out_sub_b        (out_sub_b),
    .out_sub_data_type(out_sub_data_type),
    .out_sub_int_size (out_sub_int_size),
    .out_sub_oper     (out_sub_oper)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Current request as seen by the bench
  logic [1:0]   reqDt;
  logic [1:0]   reqSz;
  logic [3:0]   reqOper;
  logic [255:0] reqA;
  logic [255:0] reqB;
  int           K;
  int           abortElem;

  // Sub-ALU model and observation state
  int           cycle = 0;
  int           pend = 0;
  logic [63:0]  pendResult;
  int           subStartCount;
  int           validCount;
  int           validCycle;
  int           abortCycle;
  logic [255:0] gotData;
  logic         gotBad;

  task automatic checkEq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] addLanes(input logic [63:0] x, input logic [63:0] y, input int laneW);
    logic [63:0] r;
    logic [63:0] mask;
    logic [63:0] s;
    r = '0;
    mask = (laneW == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << laneW) - 64'd1);
    for (int l = 0; l < 64 / laneW; l++) begin
      s = ((x >> (l * laneW)) + (y >> (l * laneW))) & mask;
      r = r | (s << (l * laneW));
    end
    return r;
  endfunction

  function automatic int elemCount(input logic [1:0] dt);
    if (dt == DataTypReserved) return 0;
    if (dt == DataTypBFloat16) return 16;
    return 4;
  endfunction

  // Expected LAR result with only the first nDone elements filled in.
  function automatic logic [255:0] refResult(input logic [1:0] dt, input logic [1:0] sz,
                                             input logic [255:0] a, input logic [255:0] b,
                                             input int nDone);
    logic [255:0] r;
    r = '0;
    if (dt == DataTypBFloat16) begin
      for (int e = 0; e < nDone; e++) r[e*16 +: 16] = a[e*16 +: 16] + b[e*16 +: 16];
    end else if (dt != DataTypReserved) begin
      for (int c = 0; c < nDone; c++) r[c*64 +: 64] = addLanes(a[c*64 +: 64], b[c*64 +: 64], 8 << sz);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: advance past the edge, update the sub-ALU model, observe outputs.
  task automatic tick();
    int e;
    logic [255:0] expA;
    logic [255:0] expB;
    logic [255:0] m16;
    logic [255:0] m64;
    m16 = 256'hffff;
    m64 = {192'd0, 64'hffff_ffff_ffff_ffff};
    @(posedge clk);
    #1;
    cycle++;
    in_sub_valid = 1'b0;
    in_abort = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        in_sub_valid = 1'b1;
        in_sub_data = pendResult;
        if (abortElem == subStartCount - 1) begin
          in_abort = 1'b1;
          abortCycle = cycle;
        end
      end
    end
    if (out_valid) begin
      validCount++;
      validCycle = cycle;
      gotData = out_data;
      gotBad = out_bad_type;
      checkEq("ready_in_done", out_ready, 0);
    end
    if (out_sub_start) begin
      e = subStartCount;
      subStartCount++;
      if (reqDt == DataTypBFloat16) begin
        expA = (reqA >> (e * 16)) & m16;
        expB = (reqB >> (e * 16)) & m16;
      end else begin
        expA = (reqA >> (e * 64)) & m64;
        expB = (reqB >> (e * 64)) & m64;
      end
      checkEq("sub_a", out_sub_a, expA);
      checkEq("sub_b", out_sub_b, expB);
      checkEq("sub_oper", out_sub_oper, reqOper);
      checkEq("sub_type", out_sub_data_type, reqDt);
      if (reqDt != DataTypBFloat16) checkEq("sub_size", out_sub_int_size, reqSz);
      pend = K;
      if (out_sub_data_type == DataTypBFloat16) begin
        // Upper bits are junk: only [15:0] may be used for BF16.
        pendResult = {16'($urandom), 32'($urandom), out_sub_a[15:0] + out_sub_b[15:0]};
      end else begin
        pendResult = addLanes(out_sub_a, out_sub_b, 8 << out_sub_int_size);
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] dt, input logic [1:0] sz,
                       input logic [255:0] a, input logic [255:0] b, input int k,
                       input bit hammer, input int abortAt);
    int startCycle;
    int nExp;
    reqDt = dt; reqSz = sz; reqOper = 4'($urandom); reqA = a; reqB = b;
    K = k; abortElem = abortAt;
    subStartCount = 0; validCount = 0;
    in_start = 1'b1; in_data_type = dt; in_int_type_size = sz; in_oper = reqOper;
    in_a = a; in_b = b;
    startCycle = cycle;
    tick();
    if (!hammer) in_start = 1'b0;
    for (int n = 0; n < 600 && validCount == 0; n++) begin
      if (hammer) begin
        in_a = rand256(); in_b = rand256(); in_oper = 4'($urandom);
        in_data_type = 2'($urandom_range(0, 3));
      end
      tick();
    end
    in_start = 1'b0;
    in_a = rand256(); in_b = rand256();
    if (validCount == 0) begin
      checkEq({tag, "_timeout"}, 0, 1);
    end else begin
      nExp = (abortAt >= 0) ? abortAt : elemCount(dt);
      if (abortAt < 0) begin
        checkEq({tag, "_latency"}, validCycle - startCycle + 1, elemCount(dt) * (k + 1) + 2);
        checkEq({tag, "_substarts"}, subStartCount, elemCount(dt));
      end else begin
        checkEq({tag, "_abort_latency"}, validCycle - abortCycle, 1);
        checkEq({tag, "_substarts"}, subStartCount, abortAt + 1);
      end
      checkEq({tag, "_data"}, gotData, refResult(dt, sz, a, b, nExp));
      checkEq({tag, "_bad"}, gotBad, (dt == DataTypReserved) || (abortAt >= 0));
    end
    tick();
    tick();
    checkEq({tag, "_one_valid"}, validCount, 1);
    checkEq({tag, "_ready_after"}, out_ready, 1);
    checkEq({tag, "_data_held"}, out_data, gotData);
  endtask

  initial begin
    logic [255:0] a;
    logic [255:0] b;
    int startsAtReset;
    rst = 1'b1; in_start = 1'b0; in_data_type = '0; in_int_type_size = '0; in_oper = '0;
    in_a = '0; in_b = '0; in_abort = 1'b0; in_sub_valid = 1'b0; in_sub_data = '0;
    reqDt = '0; reqSz = '0; reqOper = '0; reqA = '0; reqB = '0; K = 2; abortElem = -1;
    subStartCount = 0; validCount = 0; validCycle = 0; abortCycle = 0;
    gotData = '0; gotBad = 1'b0; pendResult = '0;
    repeat (3) tick();
    checkEq("rst_ready", out_ready, 1);
    checkEq("rst_valid", out_valid, 0);
    checkEq("rst_bad", out_bad_type, 0);
    checkEq("rst_substart", out_sub_start, 0);
    checkEq("rst_data", out_data, 0);
    checkEq("rst_sub_a", out_sub_a, 0);
    checkEq("rst_sub_oper", out_sub_oper, 0);
    rst = 1'b0;
    tick();

    // Unsigned 64-bit chunks: 1 + 2 in every chunk
    runOp("int64", DataTypUnsgnInt, IntTypSz64, {4{64'd1}}, {4{64'd2}}, 2, 1'b0, -1);
    checkEq("int64_const", gotData, {4{64'd3}});

    // BF16 elements a[i]=i, b=0
    for (int i = 0; i < 16; i++) a[i*16 +: 16] = 16'(i);
    runOp("bf16", DataTypBFloat16, IntTypSz8, a, 256'd0, 2, 1'b0, -1);
    checkEq("bf16_const", gotData, a);

    // Reserved type: rejected with no sub-ALU traffic
    runOp("resv", DataTypReserved, IntTypSz32, rand256(), rand256(), 2, 1'b0, -1);
    checkEq("resv_zero", gotData, 0);

    // in_start held high for the whole op
    runOp("hammer", DataTypSgnInt, IntTypSz16, rand256(), rand256(), 2, 1'b1, -1);

    // Reset while waiting on chunk 2, with the response arriving afterwards
    a = rand256(); b = rand256();
    reqDt = DataTypUnsgnInt; reqSz = IntTypSz8; reqOper = 4'd5; reqA = a; reqB = b;
    K = 2; abortElem = -1; subStartCount = 0; validCount = 0;
    in_start = 1'b1; in_data_type = reqDt; in_int_type_size = reqSz; in_oper = reqOper;
    in_a = a; in_b = b;
    tick();
    in_start = 1'b0;
    for (int n = 0; n < 100 && subStartCount < 3; n++) tick();
    checkEq("rstmid_reached", subStartCount, 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    startsAtReset = subStartCount;
    repeat (6) tick();
    checkEq("rstmid_ready", out_ready, 1);
    checkEq("rstmid_data", out_data, 0);
    checkEq("rstmid_novalid", validCount, 0);
    checkEq("rstmid_nostart", subStartCount, startsAtReset);

`ifdef SNOW64_LAR_SEQ_ABORT_EN
    runOp("abort", DataTypBFloat16, IntTypSz8, rand256(), rand256(), 2, 1'b0, 5);
`endif

    // Random mix of types, sizes and sub-ALU response delays
    for (int t = 0; t < 25; t++) begin
      runOp("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            rand256(), rand256(), $urandom_range(1, 3), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
